// File: rtl/fir_pkg.sv
// Shared constants, state encoding and the round/saturate helper used by the
// blocks on the FIR output path.
package fir_pkg;

    localparam int coefWidth  = 8;
    localparam int dataWidth  = 8;
    localparam int DATA_IN_W  = 15;
    localparam int DATA_OUT_W = 8;
    localparam int DECIM      = 4;

    localparam int RS_SHIFT = DATA_IN_W - DATA_OUT_W;
    localparam int RS_HALF  = 2 ** (RS_SHIFT - 1);
    localparam int SAT_MAX  = 2 ** (DATA_OUT_W - 1) - 1;
    localparam int SAT_MIN  = -(2 ** (DATA_OUT_W - 1));

    localparam logic signed [DATA_IN_W:0] Q_MAX =
        (DATA_IN_W + 1)'(SAT_MAX);
    localparam logic signed [DATA_IN_W:0] Q_MIN =
        (DATA_IN_W + 1)'(SAT_MIN);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_RUN
    } state_t;

    // Round half up, then clamp. One guard bit keeps x + half from
    // wrapping at the top of the input range.
    function automatic logic [DATA_OUT_W-1:0] round_sat(
        input logic signed [DATA_IN_W-1:0] x
    );
        logic signed [DATA_IN_W:0] sum;
        logic signed [DATA_IN_W:0] q;
        sum = (DATA_IN_W + 1)'(x) + (DATA_IN_W + 1)'(RS_HALF);
        q   = sum >>> RS_SHIFT;
        if (q > Q_MAX) return DATA_OUT_W'(SAT_MAX);
        if (q < Q_MIN) return DATA_OUT_W'(SAT_MIN);
        return q[DATA_OUT_W-1:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with synchronous flush.
// Ports: clk, rst_n (sync, active-low), flush, push/wdata, pop/rdata,
//        full, empty, level (occupancy 0..DEPTH).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    import fir_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [LW-1:0]    r_level;
    logic             w_wr;
    logic             w_rd;

    assign full  = (r_level == LW'(DEPTH));
    assign empty = (r_level == '0);
    assign level = r_level;

    // A pop frees the slot, so a push into a full FIFO with a
    // simultaneous pop is accepted.
    assign w_wr = push && (!full || pop);
    assign w_rd = pop && !empty;

    // Head reads as zero while empty so the output has a defined value.
    assign rdata = empty ? '0 : r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (w_wr) r_wr <= r_wr + 1'b1;
            if (w_rd) r_rd <= r_rd + 1'b1;
            unique case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/fir_out_decimator.sv
// Drops fir_filter warm-up samples, keeps one of every DECIM samples,
// rounds/saturates to DATA_OUT_W bits and buffers into a show-ahead FIFO.
// Ports: clk, reset (sync, active-low), load_c, data_in, phase,
//        out_data/out_valid/out_ready, fifo_level, overflow (sticky).
module fir_out_decimator #(
    parameter int DATA_IN_W  = fir_pkg::DATA_IN_W,
    parameter int DATA_OUT_W = fir_pkg::DATA_OUT_W,
    parameter int DECIM      = fir_pkg::DECIM,
    parameter int WARMUP     = 24,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load_c,
    input  logic [DATA_IN_W-1:0]          data_in,
    input  logic [$clog2(DECIM)-1:0]      phase,
    output logic [DATA_OUT_W-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);
    import fir_pkg::*;

    localparam int PW = $clog2(DECIM);
    localparam int CW = $clog2(WARMUP + 1);

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [PW-1:0]         r_phase;
    logic                  r_stg_vld;
    logic [DATA_OUT_W-1:0] r_stg_data;
    logic                  r_ovf;

    logic w_keep;
    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_empty;
    logic w_drop;

    assign w_keep = (r_state == ST_RUN) && (r_cnt == CW'(r_phase));
    // load_c wins over the sample sitting in the stage register.
    assign w_push = r_stg_vld && !load_c;
    assign w_pop  = !w_empty && out_ready;
    assign w_drop = w_push && w_full && !w_pop;

    assign out_valid = !w_empty;
    assign overflow  = r_ovf;

    always_ff @(posedge clk) begin
        if (!reset || load_c) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_phase    <= '0;
            r_stg_vld  <= 1'b0;
            r_stg_data <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_stg_vld <= w_keep;
            if (w_keep) r_stg_data <= round_sat(data_in);
            if (w_drop) r_ovf <= 1'b1;
            unique case (r_state)
                // The first low cycle is itself the first discarded
                // sample, so warm-up counting starts at 1.
                ST_IDLE: begin
                    r_state <= ST_WARMUP;
                    r_phase <= phase;
                    r_cnt   <= CW'(1);
                end
                ST_WARMUP: begin
                    if (r_cnt == CW'(WARMUP - 1)) begin
                        r_state <= ST_RUN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (r_cnt == CW'(DECIM - 1)) r_cnt <= '0;
                    else                         r_cnt <= r_cnt + 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (DATA_OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .flush (load_c),
        .push  (w_push),
        .wdata (r_stg_data),
        .pop   (w_pop),
        .rdata (out_data),
        .full  (w_full),
        .empty (w_empty),
        .level (fifo_level)
    );

endmodule

// File: tb/tb_fir_out_decimator.sv
// Bench for fir_out_decimator: directed scenarios plus random traffic,
// compared cycle by cycle against a queue-based reference model.
module tb_fir_out_decimator;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_c;
    logic [14:0] data_in;
    logic [1:0]  phase;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  fifo_level;
    logic        overflow;

    always #5 clk = ~clk;

    fir_out_decimator dut (
        .clk        (clk),
        .reset      (reset),
        .load_c     (load_c),
        .data_in    (data_in),
        .phase      (phase),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state
    int mq[$];
    bit pend = 0;
    int pend_v = 0;
    bit m_ovf = 0;
    int k = 0;
    int ph_l = 0;

    int got[$];
    int snap[$];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sx(logic [14:0] d);
        return {{17{d[14]}}, d};
    endfunction

    // floor((v + 64) / 128), clamped to the signed 8-bit range
    function automatic int rs(int v);
        int r;
        int q;
        r = v + 64;
        q = (r >= 0) ? r / 128 : -((-r + 127) / 128);
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return q & 255;
    endfunction

    function automatic int gv(int i);
        return (i < got.size()) ? got[i] : -1;
    endfunction

    task automatic model_step(bit ld, logic [14:0] d, logic [1:0] ph,
                              bit rdy, bit rn);
        if (!rn || ld) begin
            mq.delete();
            pend = 0;
            m_ovf = 0;
            k = 0;
        end else begin
            if (rdy && mq.size() > 0) void'(mq.pop_front());
            if (pend) begin
                if (mq.size() < 8) mq.push_back(pend_v);
                else m_ovf = 1;
            end
            if (k == 0) ph_l = ph;
            pend = (k >= 24) && (((k - 24) % 4) == ph_l);
            pend_v = rs(sx(d));
            k++;
        end
    endtask

    task automatic cyc(bit ld, logic [14:0] d, logic [1:0] ph, bit rdy,
                       bit rn = 1'b1);
        chk("valid", 32'(out_valid), 32'(mq.size() > 0));
        chk("level", 32'(fifo_level), 32'(mq.size()));
        chk("ovf", 32'(overflow), 32'(m_ovf));
        if (mq.size() > 0) chk("data", 32'(out_data), 32'(mq[0]));
        if (out_valid === 1'b1 && rdy) got.push_back(int'(out_data));
        reset = rn;
        load_c = ld;
        data_in = d;
        phase = ph;
        out_ready = rdy;
        @(posedge clk);
        model_step(ld, d, ph, rdy, rn);
        #1;
    endtask

    task automatic load(int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 15'($urandom), 2'd0, 1'b1);
    endtask

    logic [14:0] rv [6];
    int          re [6];

    initial begin
        reset = 1'b0;
        load_c = 1'b0;
        data_in = '0;
        phase = '0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        cyc(1'b0, 15'd0, 2'd0, 1'b0, 1'b0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_ovf", 32'(overflow), 0);

        // Warm-up drop, phase 0
        load(25);
        got.delete();
        for (int i = 0; i < 80; i++) cyc(1'b0, 15'(i << 7), 2'd0, 1'b1);
        chk("wu_first", gv(0), 24);
        chk("wu_second", gv(1), 28);
        chk("wu_third", gv(2), 32);
        chk("wu_count", got.size(), 14);

        // Phase select
        load(25);
        got.delete();
        for (int i = 0; i < 80; i++) cyc(1'b0, 15'(i << 7), 2'd3, 1'b1);
        chk("ph3_first", gv(0), 27);
        chk("ph3_second", gv(1), 31);

        // Round / saturate boundaries
        rv[0] = 15'h003F; re[0] = 8'h00;
        rv[1] = 15'h0040; re[1] = 8'h01;
        rv[2] = 15'h3FFF; re[2] = 8'h7F;
        rv[3] = 15'h4000; re[3] = 8'h80;
        rv[4] = 15'h7FC0; re[4] = 8'h00;
        rv[5] = 15'h7FBF; re[5] = 8'hFF;
        load(25);
        got.delete();
        for (int i = 0; i < 24; i++) cyc(1'b0, 15'd0, 2'd0, 1'b1);
        for (int j = 0; j < 6; j++)
            for (int i = 0; i < 4; i++) cyc(1'b0, rv[j], 2'd0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 15'd0, 2'd0, 1'b1);
        for (int j = 0; j < 6; j++) chk($sformatf("rs%0d", j), gv(j), re[j]);

        // Backpressure / overflow
        load(25);
        for (int i = 0; i < 24 + 40 * 4; i++)
            cyc(1'b0, 15'($urandom), 2'd0, 1'b0);
        chk("bp_level", 32'(fifo_level), 8);
        chk("bp_ovf", 32'(overflow), 1);
        snap = mq;
        got.delete();
        for (int i = 0; i < 8; i++) cyc(1'b0, 15'($urandom), 2'd0, 1'b1);
        chk("bp_drained", got.size(), 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("bp_d%0d", i), gv(i), snap[i]);
        chk("bp_ovf_hold", 32'(overflow), 1);

        // Full with a pop on the push cycle
        load(25);
        for (int i = 0; i < 200 && mq.size() < 8; i++)
            cyc(1'b0, 15'($urandom), 2'd1, 1'b0);
        for (int i = 0; i < 24; i++)
            cyc(1'b0, 15'($urandom), 2'd1, pend);
        chk("fp_level", 32'(fifo_level), 8);
        chk("fp_ovf", 32'(overflow), 0);

        // Mid-run reload with 5 entries queued
        load(25);
        for (int i = 0; i < 200 && mq.size() < 5; i++)
            cyc(1'b0, 15'($urandom), 2'd2, 1'b0);
        chk("rl_pre", 32'(fifo_level), 5);
        cyc(1'b1, 15'($urandom), 2'd0, 1'b0);
        chk("rl_valid", 32'(out_valid), 0);
        chk("rl_level", 32'(fifo_level), 0);
        chk("rl_ovf", 32'(overflow), 0);
        got.delete();
        for (int i = 0; i < 40; i++) cyc(1'b0, 15'(i << 7), 2'd0, 1'b1);
        chk("rl_first", gv(0), 24);

        // One-cycle reset mid-stream, FIFO full and overflowed
        for (int i = 0; i < 60; i++) cyc(1'b0, 15'($urandom), 2'd0, 1'b0);
        cyc(1'b0, 15'($urandom), 2'd0, 1'b1, 1'b0);
        chk("mr_valid", 32'(out_valid), 0);
        chk("mr_data", 32'(out_data), 0);
        chk("mr_level", 32'(fifo_level), 0);
        chk("mr_ovf", 32'(overflow), 0);

        // Random traffic
        for (int s = 0; s < 8; s++) begin
            int thr;
            logic [1:0] ph;
            thr = $urandom_range(1, 4);
            ph = 2'($urandom);
            for (int i = 0; i < 400; i++)
                cyc(($urandom % 300) == 0, 15'($urandom), ph,
                    ($urandom % 4) < thr, ($urandom % 500) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_out_decimator.md
# fir_out_decimator

Downstream stage of `fir_filter`: consumes its per-cycle 15-bit `data_out` stream and suppresses the filter's warm-up samples after coefficient loading. It then decimates the 4x-oversampled stream by 4 and rounds/saturates each kept sample to 8 bits. Results are buffered in a small FIFO and presented on a valid/ready interface to the sample sink (file writer in simulation, packer in silicon).

## Interface
- `DATA_IN_W`, 15, width of the FIR output word (signed two's complement)
- `DATA_OUT_W`, 8, width of the emitted sample (signed)
- `DECIM`, 4, decimation ratio
- `WARMUP`, 24, samples discarded after `load_c` falls (nCoef-1)
- `FIFO_DEPTH`, 8, output buffer entries (power of two)

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-low reset
- `load_c`  in  1  same signal driving `fir_filter`; high = coefficients loading
- `data_in`  in  DATA_IN_W  `fir_filter.data_out`, one sample per cycle
- `phase`  in  $clog2(DECIM)  which sample of each group of DECIM is kept; sampled only in WARMUP
- `out_data`  out  DATA_OUT_W  FIFO head sample
- `out_valid`  out  1  FIFO non-empty
- `out_ready`  in  1  sink accepts `out_data` when `out_valid & out_ready`
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current occupancy
- `overflow`  out  1  sticky: a kept sample was dropped because the FIFO was full

## Operation
- States: IDLE, WARMUP, RUN.
- IDLE: entered on reset or whenever `load_c`=1 from any state. Behaviour on entry:
  - FIFO flushed, `overflow` cleared, counters zeroed.
  - `load_c` re-asserted mid-RUN is legal and does exactly this.
- IDLE -> WARMUP on the first cycle with `load_c`=0. `phase` is latched on that cycle.
- WARMUP: counts WARMUP cycles. Samples are ignored during this state.
- WARMUP -> RUN after the WARMUP-th ignored sample. The first RUN cycle carries decimation index 0.
- RUN: the decimation counter runs 0..DECIM-1 and wraps to 0.
  - A sample is kept when counter == latched phase, giving exactly one kept sample per DECIM cycles.
- Arithmetic, per kept sample:
  - Add 2^(DATA_IN_W-DATA_OUT_W-1) = 64.
  - Arithmetic shift right by 7.
  - Saturate to [-128, 127].
  - Round-half-up; saturation is applied after rounding.
- FIFO: show-ahead; `out_data` is valid whenever `out_valid`=1.
  - Push when full with no pop in the same cycle: the sample is dropped and `overflow` is set.
  - Push when full with a pop in the same cycle: the push succeeds and the level is unchanged.
  - Pop when empty: ignored.
- `overflow` is cleared only by reset or by entering IDLE.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `fifo_level`=0, `overflow`=0, state IDLE.
- Kept sample on `data_in` at cycle t:
  - Rounded/saturated value registered at t+1.
  - Written to the FIFO at the edge ending t+1.
  - Visible on `out_data`/`out_valid` at t+2 if the FIFO was empty.
- With `load_c` falling at cycle L:
  - Cycles L..L+23 are discarded.
  - Cycle L+24 has decimation index 0.
- Transfer occurs on a cycle with `out_valid & out_ready`. The head advances on the next cycle.
- `fifo_level` updates one cycle after a push/pop and reflects simultaneous push+pop as net 0.
- `load_c`=1 takes priority over an in-flight push: an in-flight sample is discarded, not written.
- Sustained rate: 1 sample per DECIM cycles. `out_ready` stalls up to FIFO_DEPTH*DECIM cycles lose nothing.

## Structure
- Shared package `fir_pkg` holds:
  - The width constants (coefWidth, dataWidth, DATA_IN_W, DATA_OUT_W) and DECIM.
  - The state enum {IDLE, WARMUP, RUN}.
  - A `round_sat` function reused by other FIR-path blocks.
- One sub-module, `sync_fifo`: a parameterised width/depth show-ahead FIFO with flush, full, empty and level outputs.
- The top module contains the FSM, counters and the round/saturate stage register.

## Test plan
- Warm-up drop: `load_c` high for 25 cycles, then low; drive `data_in`=k<<7 on cycle k after the fall, `phase`=0, `out_ready`=1 -> first `out_data`=24, then 28, 32, ...; nothing emitted before.
- Phase select: same stimulus, `phase`=3 -> outputs 27, 31, 35, ...
- Round/saturate, `phase`=0:
  - `data_in`=0x003F -> 0; 0x0040 -> 1.
  - 0x3FFF -> 127.
  - 0x4000 (-16384) -> -128.
  - 0x7FC0 (-64) -> 0; 0x7FBF -> -1.
- Backpressure/overflow: `out_ready`=0 for 40 kept samples -> `fifo_level`=8 and `overflow`=1 after the 9th kept sample; release -> exactly 8 samples (the first 8) drain, and `overflow` stays 1.
- Full with simultaneous pop: FIFO full, `out_ready`=1 on the kept-sample cycle -> level stays 8 and no drop (`overflow`=0).
- Mid-run reload and reset: `load_c` pulsed during RUN with 5 entries queued -> next cycle `out_valid`=0, `fifo_level`=0, `overflow`=0, and warm-up restarts; `reset`=0 for one cycle mid-stream -> all outputs at reset values.
